// File: rtl/hack_decode_stage_if.sv
// Handshake/bus bundle for hack_decode_stage: fetch-side beat in, decoded control bundle out.
// master = the environment (fetch + execute), slave = the decode stage.
interface hack_decode_stage_if #(
    parameter int WIDTH = 16,
    parameter int PC_W  = 15
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_inst;
    logic [PC_W-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [PC_W-1:0]  out_pc;
    logic             out_is_c;
    logic [WIDTH-2:0] out_a_val;
    logic             out_a_sel;
    logic [5:0]       out_comp;
    logic             out_load_a;
    logic             out_load_d;
    logic             out_write_m;
    logic [2:0]       out_jump;
    logic             out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_is_c, out_a_val, out_a_sel,
               out_comp, out_load_a, out_load_d, out_write_m, out_jump, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_is_c, out_a_val, out_a_sel,
               out_comp, out_load_a, out_load_d, out_write_m, out_jump, out_illegal
    );
endinterface

// File: rtl/hack_decode_stage.sv
// Hack instruction decode stage: one registered output entry plus a skid entry so the
// stage sustains one beat per cycle while in_ready stays a pure register output.
// Optional feature: define HACK_DEC_ILLEGAL_EN to flag C-instructions whose
// inst[WIDTH-2:13] are not all ones and suppress their side effects.
module hack_decode_stage #(
    parameter int WIDTH = 16,
    parameter int PC_W  = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    hack_decode_stage_if.slave bus
);

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic             is_c;
        logic [WIDTH-2:0] a_val;
        logic             a_sel;
        logic [5:0]       comp;
        logic             load_a;
        logic             load_d;
        logic             write_m;
        logic [2:0]       jump;
        logic             illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t  state_q, state_d;
    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    bundle_t dec;
    logic    ready_int;
    logic    valid_int;
    logic    accept;
    logic    drain;

    // Flatten one instruction word into the execute-stage control bundle.
    function automatic bundle_t decode(input logic [WIDTH-1:0] inst, input logic [PC_W-1:0] pc);
        bundle_t b;
        b      = '0;
        b.pc   = pc;
        b.is_c = inst[WIDTH-1];
        if (!inst[WIDTH-1]) begin
            b.a_val  = inst[WIDTH-2:0];
            b.load_a = 1'b1;
        end else begin
            b.a_sel   = inst[12];
            b.comp    = inst[11:6];
            b.load_a  = inst[5];
            b.load_d  = inst[4];
            b.write_m = inst[3];
            b.jump    = inst[2:0];
`ifdef HACK_DEC_ILLEGAL_EN
            // Malformed prefix: keep ALU fields for debug, but kill every architectural write.
            if (!(&inst[WIDTH-2:13])) begin
                b.illegal = 1'b1;
                b.load_a  = 1'b0;
                b.load_d  = 1'b0;
                b.write_m = 1'b0;
                b.jump    = 3'b000;
            end
`endif
        end
        return b;
    endfunction

    assign ready_int = (state_q != FULL);
    assign valid_int = (state_q != EMPTY);
    assign accept    = bus.in_valid & ready_int & ~bus.flush;
    assign drain     = valid_int & bus.out_ready;
    assign dec       = decode(bus.in_inst, bus.in_pc);

    // State register: occupancy of the OUT/SKID pair.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Entry registers: reset clears the bundle so outputs read zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            out_q  <= out_d;
            skid_q <= skid_d;
        end
    end

    // Next occupancy; flush empties both entries regardless of traffic.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !drain)      state_d = FULL;
                    else if (!accept && drain) state_d = EMPTY;
                end
                FULL:    if (drain) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Entry data movement; entries hold unless a beat lands or SKID promotes to OUT.
    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        case (state_q)
            EMPTY: if (accept) out_d = dec;
            ONE: begin
                if (accept && drain) out_d  = dec;
                else if (accept)     skid_d = dec;
            end
            FULL:    if (drain) out_d = skid_q;
            default: ;
        endcase
    end

    // Outputs are straight from registers: no combinational path from out_ready.
    always_comb begin
        bus.in_ready    = ready_int;
        bus.out_valid   = valid_int;
        bus.out_pc      = out_q.pc;
        bus.out_is_c    = out_q.is_c;
        bus.out_a_val   = out_q.a_val;
        bus.out_a_sel   = out_q.a_sel;
        bus.out_comp    = out_q.comp;
        bus.out_load_a  = out_q.load_a;
        bus.out_load_d  = out_q.load_d;
        bus.out_write_m = out_q.write_m;
        bus.out_jump    = out_q.jump;
        bus.out_illegal = out_q.illegal;
    end

endmodule

// File: tb/tb_hack_decode_stage.sv
// Bench for hack_decode_stage: directed steps followed by random traffic, all checked
// against an occupancy queue plus an arithmetic decode reference.
module tb_hack_decode_stage;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    hack_decode_stage_if #(.WIDTH(16), .PC_W(15)) bus ();

    hack_decode_stage #(.WIDTH(16), .PC_W(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected contents of the stage in program order: {pc, inst}.
    logic [30:0] q[$];

    typedef struct packed {
        logic [14:0] pc;
        logic        is_c;
        logic [14:0] a_val;
        logic        a_sel;
        logic [5:0]  comp;
        logic        la;
        logic        ld;
        logic        wm;
        logic [2:0]  jump;
        logic        ill;
    } exp_t;

    function automatic exp_t ref_decode(input int unsigned inst, input int unsigned pc);
        exp_t e;
        e      = '0;
        e.pc   = 15'(pc % 32768);
        e.is_c = ((inst / 32768) % 2) == 1;
        if (!e.is_c) begin
            e.a_val = 15'(inst % 32768);
            e.la    = 1'b1;
        end else begin
            e.a_sel = ((inst / 4096) % 2) == 1;
            e.comp  = 6'((inst / 64) % 64);
            e.la    = ((inst / 32) % 2) == 1;
            e.ld    = ((inst / 16) % 2) == 1;
            e.wm    = ((inst / 8) % 2) == 1;
            e.jump  = 3'(inst % 8);
`ifdef HACK_DEC_ILLEGAL_EN
            if (((inst / 8192) % 4) != 3) begin
                e.ill  = 1'b1;
                e.la   = 1'b0;
                e.ld   = 1'b0;
                e.wm   = 1'b0;
                e.jump = 3'd0;
            end
`endif
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bundle(input string tag, input logic [30:0] ent);
        exp_t e;
        e = ref_decode(int'(ent[15:0]), int'(ent[30:16]));
        check({tag, ".pc"},      32'(bus.out_pc),      32'(e.pc));
        check({tag, ".is_c"},    32'(bus.out_is_c),    32'(e.is_c));
        check({tag, ".a_val"},   32'(bus.out_a_val),   32'(e.a_val));
        check({tag, ".a_sel"},   32'(bus.out_a_sel),   32'(e.a_sel));
        check({tag, ".comp"},    32'(bus.out_comp),    32'(e.comp));
        check({tag, ".load_a"},  32'(bus.out_load_a),  32'(e.la));
        check({tag, ".load_d"},  32'(bus.out_load_d),  32'(e.ld));
        check({tag, ".write_m"}, 32'(bus.out_write_m), 32'(e.wm));
        check({tag, ".jump"},    32'(bus.out_jump),    32'(e.jump));
        check({tag, ".illegal"}, 32'(bus.out_illegal), 32'(e.ill));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".in_ready"},  32'(bus.in_ready),  32'd1);
        check({tag, ".fields"},
              {bus.out_pc, bus.out_is_c, bus.out_a_val[14:0], bus.out_illegal},
              32'd0);
        check({tag, ".ctrl"},
              32'({bus.out_a_sel, bus.out_comp, bus.out_load_a, bus.out_load_d,
                   bus.out_write_m, bus.out_jump}), 32'd0);
    endtask

    // One clock: drive, compare against the model before the edge, update the model.
    task automatic step(input bit iv, input int unsigned inst, input int unsigned pc,
                        input bit fl, input bit ordy, input bit rn, output bit acc);
        bit rdy;
        bus.in_valid  = iv;
        bus.in_inst   = 16'(inst);
        bus.in_pc     = 15'(pc);
        bus.flush     = fl;
        bus.out_ready = ordy;
        rst_n         = rn;
        acc           = 1'b0;
        @(negedge clk);
        rdy = (q.size() < 2);
        check("in_ready",  32'(bus.in_ready),  32'(rdy));
        check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) check_bundle("head", q[0]);
        if (!rn) begin
            q.delete();
        end else begin
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (fl) q.delete();
            else if (iv && rdy) begin
                q.push_back({15'(pc), 16'(inst)});
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        bit got;
        n_assert      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 16'h1234;
        bus.in_pc     = 15'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_zero("reset");
        q.delete();

        // A-instruction then C-instruction D=A, streaming.
        step(1, 32'h0005, 0, 0, 1, 1, acc);
        check("a5.valid",  32'(bus.out_valid),  32'd1);
        check("a5.is_c",   32'(bus.out_is_c),   32'd0);
        check("a5.a_val",  32'(bus.out_a_val),  32'h5);
        check("a5.load_a", 32'(bus.out_load_a), 32'd1);
        check("a5.ld_wm_j", 32'({bus.out_load_d, bus.out_write_m, bus.out_jump}), 32'd0);
        step(1, 32'hEC10, 1, 0, 1, 1, acc);
        check("c.is_c",    32'(bus.out_is_c),   32'd1);
        check("c.a_sel",   32'(bus.out_a_sel),  32'd0);
        check("c.comp",    32'(bus.out_comp),   32'b110000);
        check("c.load_d",  32'(bus.out_load_d), 32'd1);
        check("c.load_a",  32'(bus.out_load_a), 32'd0);
        check("c.write_m", 32'(bus.out_write_m), 32'd0);
        check("c.jump",    32'(bus.out_jump),   32'd0);
        check("c.pc",      32'(bus.out_pc),     32'd1);
        step(0, 0, 0, 0, 1, 1, acc);

        // Backpressure: third beat must stall until the skid drains.
        step(1, 32'h0001, 2, 0, 0, 1, acc);
        check("bp.acc1", 32'(acc), 32'd1);
        step(1, 32'h0002, 3, 0, 0, 1, acc);
        check("bp.acc2", 32'(acc), 32'd1);
        check("bp.full_ready", 32'(bus.in_ready), 32'd0);
        step(1, 32'h0003, 4, 0, 0, 1, acc);
        check("bp.acc3_blocked", 32'(acc), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            step(1, 32'h0003, 4, 0, 1, 1, acc);
            got = acc;
        end
        check("bp.acc3_eventually", 32'(got), 32'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, acc);

        // Flush while full with a beat offered: everything disappears.
        step(1, 32'h0010, 5, 0, 0, 1, acc);
        step(1, 32'h0011, 6, 0, 0, 1, acc);
        step(1, 32'h0009, 7, 1, 0, 1, acc);
        check("flush.valid", 32'(bus.out_valid), 32'd0);
        check("flush.ready", 32'(bus.in_ready),  32'd1);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1, 1, acc);

        // Malformed C-instruction prefix.
        step(1, 32'h8008, 8, 0, 1, 1, acc);
`ifdef HACK_DEC_ILLEGAL_EN
        check("ill.flag",    32'(bus.out_illegal), 32'd1);
        check("ill.write_m", 32'(bus.out_write_m), 32'd0);
`else
        check("ill.flag",    32'(bus.out_illegal), 32'd0);
        check("ill.write_m", 32'(bus.out_write_m), 32'd1);
`endif
        step(0, 0, 0, 0, 1, 1, acc);

        // Reset while full; offered beat during reset is ignored.
        step(1, 32'h0020, 9, 0, 0, 1, acc);
        step(1, 32'h0021, 10, 0, 0, 1, acc);
        step(1, 32'h0022, 11, 0, 0, 0, acc);
        check_zero("midreset");
        step(1, 32'h0007, 12, 0, 1, 1, acc);
        check("post.valid", 32'(bus.out_valid), 32'd1);
        check("post.a_val", 32'(bus.out_a_val), 32'h7);
        check("post.pc",    32'(bus.out_pc),    32'd12);
        step(0, 0, 0, 0, 1, 1, acc);

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 65535), $urandom_range(0, 32767),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 59) != 0, acc);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
